// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: groups the CPU-side (EX/MEM) and memory-side handshake
// signals of the data cache controller. The slave modport is the cache
// controller's view; the master modport is the environment's view.
interface dcache_ctrl_if #(
  parameter int LINE_W = 256
);
  logic              cpu_rd_i;
  logic              cpu_wr_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: MEM-stage data cache controller. Direct-mapped, write-back,
// write-allocate; hits are served with no stall, misses stall the pipeline
// while a line is written back (if dirty) and refilled over a req/ack bus.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        word;
  logic              req;
  logic              is_load;
  logic              hit;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_line;
  logic [31:0]       line_word;
  logic              write_hit;
  logic              fill_done;
  logic              unused_addr_bits;

  // Field split of the registered address; the byte offset is never used
  // because only word accesses exist.
  assign tag              = bus.cpu_addr_i[31:5+IDX_W];
  assign idx              = bus.cpu_addr_i[5+IDX_W-1:5];
  assign word             = bus.cpu_addr_i[4:2];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  // A simultaneous read and write is a store.
  assign req     = bus.cpu_rd_i | bus.cpu_wr_i;
  assign is_load = bus.cpu_rd_i & ~bus.cpu_wr_i;

  assign victim_tag  = tag_mem[idx];
  assign victim_line = data_mem[idx];
  assign line_word   = victim_line[{word, 5'b00000} +: 32];
  assign hit         = valid[idx] && (victim_tag == tag);
  assign write_hit   = (state == IDLE) && bus.cpu_wr_i && hit;
  assign fill_done   = (state == ALLOCATE) && bus.mem_ack_i;

  // State register; reset aborts any miss in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a dirty victim is written back before the refill.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ack_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is asserted so the
  // pipeline is released even if a request is sitting on the inputs.
  always_comb begin
    bus.cpu_stall_o = 1'b0;
    bus.cpu_rdata_o = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (rst_i) begin
      case (state)
        IDLE: begin
          bus.cpu_stall_o = req & ~hit;
          if (is_load && hit) begin
            bus.cpu_rdata_o = line_word;
          end
        end
        WRITEBACK: begin
          bus.cpu_stall_o = 1'b1;
          bus.mem_req_o   = 1'b1;
          bus.mem_we_o    = 1'b1;
          bus.mem_addr_o  = {victim_tag, idx, 5'b00000};
          bus.mem_wdata_o = victim_line;
        end
        ALLOCATE: begin
          bus.cpu_stall_o = 1'b1;
          bus.mem_req_o   = 1'b1;
          bus.mem_addr_o  = {tag, idx, 5'b00000};
        end
        default: begin
          bus.cpu_stall_o = 1'b0;
        end
      endcase
    end
  end

  // Line status bits: a fill installs a clean valid line, a store hit marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (write_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; their contents only matter once valid.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_mem[idx] <= bus.mem_rdata_i;
      tag_mem[idx]  <= tag;
    end else if (write_hit) begin
      data_mem[idx][{word, 5'b00000} +: 32] <= bus.cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill;

  // Hit/miss counters; the lookup right after a refill is not a new hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill     <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      refill <= fill_done;
      if ((state == IDLE) && req) begin
        if (!hit) begin
          miss_cnt_o <= miss_cnt_o + 32'd1;
        end else if (!refill) begin
          hit_cnt_o <= hit_cnt_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: drives directed and random accesses into dcache_ctrl and
// checks them against an architectural memory model plus a line-residency
// model used to predict hits, write-backs and stall lengths.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  localparam int NUM_LINES = 16;
  localparam int LINE_W    = 256;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  dcache_ctrl_if #(.LINE_W(LINE_W)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  dcache_ctrl #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Architectural view: CPU stores on top of the external memory contents.
  logic [31:0]       stored  [logic [31:0]];
  logic [LINE_W-1:0] ext_mem [logic [31:0]];

  // Which line occupies each slot and whether it has been written since fill.
  logic [31:0] res_line  [NUM_LINES];
  bit          res_valid [NUM_LINES];
  bit          res_dirty [NUM_LINES];

  int model_hits   = 0;
  int model_misses = 0;

  // Expectations shared with the compare process.
  bit          checking      = 0;
  bit          in_access     = 0;
  bit          exp_rd_only   = 0;
  logic [31:0] exp_addr      = '0;
  bit          exp_wb_ok     = 0;
  logic [31:0] exp_wb_addr   = '0;
  bit          exp_fill_ok   = 0;
  logic [31:0] exp_fill_addr = '0;
  logic [31:0] last_wb_addr  = '0;
  logic [LINE_W-1:0] last_wb_line = '0;
  int          lat           = 1;
  bit          aborted       = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [LINE_W-1:0] ext_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (ext_mem.exists(la)) return ext_mem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [31:0]       wa;
    logic [LINE_W-1:0] l;
    int                w;
    wa = {a[31:2], 2'b00};
    if (stored.exists(wa)) return stored[wa];
    l = ext_line({a[31:5], 5'b00000});
    w = int'(a[4:2]);
    return l[w*32 +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] arch_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) & 32'(NUM_LINES - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      res_valid[i] = 0;
      res_dirty[i] = 0;
      res_line[i]  = '0;
    end
    stored.delete();
    model_hits   = 0;
    model_misses = 0;
  endtask

  // Memory responder: acks each request after 'lat' cycles, commits
  // write-backs one cycle later and throws in stray acks while idle.
  int          mem_cnt  = 0;
  bit          pend_wr  = 0;
  logic [31:0] pend_addr;
  logic [LINE_W-1:0] pend_line;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      mem_cnt         = 0;
      pend_wr         = 0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
    end else begin
      if (pend_wr) begin
        ext_mem[pend_addr] = pend_line;
        pend_wr = 0;
      end
      if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
        mem_cnt = 0;
      end
      if (bus.mem_req_o) begin
        mem_cnt++;
        if (mem_cnt >= lat) begin
          mem_cnt       = 0;
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o) begin
            pend_wr   = 1;
            pend_addr = bus.mem_addr_o;
            pend_line = bus.mem_wdata_o;
            bus.mem_rdata_i = {8{$urandom}};
          end else begin
            bus.mem_rdata_i = ext_line(bus.mem_addr_o);
          end
        end
      end else begin
        mem_cnt = 0;
        if ($urandom_range(0, 7) == 0) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = {8{$urandom}};
        end
      end
    end
  end

  // Per-cycle comparison of memory traffic and load data against the model.
  always @(negedge clk_i) begin
    if (rst_i && checking) begin
      if (bus.mem_req_o) begin
        if (bus.mem_we_o) begin
          checkOutput("wb_allowed", exp_wb_ok, 1'b1);
          checkOutput("wb_addr", bus.mem_addr_o, exp_wb_addr);
          checkOutput("wb_data", bus.mem_wdata_o, arch_line(exp_wb_addr));
          last_wb_addr = bus.mem_addr_o;
          last_wb_line = bus.mem_wdata_o;
        end else begin
          checkOutput("fill_allowed", exp_fill_ok, 1'b1);
          checkOutput("fill_addr", bus.mem_addr_o, exp_fill_addr);
        end
      end
      if (!bus.cpu_stall_o) begin
        if (in_access && exp_rd_only)
          checkOutput("load_data", bus.cpu_rdata_o, arch_word(exp_addr));
        else
          checkOutput("rdata_zero", bus.cpu_rdata_o, 32'h0);
      end
      if (!in_access) checkOutput("idle_stall", bus.cpu_stall_o, 1'b0);
    end
  end

  // One complete CPU access: called at posedge+1, returns at posedge+1.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int n,
                               output int stalls, output logic [31:0] rdata);
    int          i;
    logic [31:0] la;
    bit          hit;
    bit          wb;
    int          exp_stalls;
    i   = idx_of(addr);
    la  = {addr[31:5], 5'b00000};
    hit = res_valid[i] && (res_line[i] == la);
    wb  = !hit && res_valid[i] && res_dirty[i];
    exp_stalls = hit ? 0 : (wb ? 2 * n + 1 : n + 1);
    lat           = n;
    exp_wb_ok     = wb;
    exp_wb_addr   = res_line[i];
    exp_fill_ok   = !hit;
    exp_fill_addr = la;
    exp_rd_only   = rd && !wr;
    exp_addr      = addr;
    in_access     = 1;
    bus.cpu_rd_i    = rd;
    bus.cpu_wr_i    = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    stalls = 0;
    forever begin
      @(negedge clk_i);
      if (!bus.cpu_stall_o) break;
      stalls++;
      if (stalls > 40) begin
        checkOutput("stall_timeout", 32'(stalls), 32'(exp_stalls));
        aborted = 1;
        break;
      end
    end
    rdata = bus.cpu_rdata_o;
    if (!aborted) checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk_i);
    if (hit) model_hits++;
    else     model_misses++;
    res_dirty[i] = hit ? (res_dirty[i] | wr) : wr;
    res_valid[i] = 1;
    res_line[i]  = la;
    if (wr) stored[{addr[31:2], 2'b00}] = wdata;
    in_access   = 0;
    exp_wb_ok   = 0;
    exp_fill_ok = 0;
    exp_rd_only = 0;
    #1;
    bus.cpu_rd_i = 1'b0;
    bus.cpu_wr_i = 1'b0;
  endtask

  // Bound on total run time.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          s;
    logic [31:0] r;
    model_reset();
    bus.cpu_rd_i    = 1'b1;
    bus.cpu_wr_i    = 1'b0;
    bus.cpu_addr_i  = 32'h40;
    bus.cpu_wdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_stall", bus.cpu_stall_o, 1'b0);
    checkOutput("rst_req",   bus.mem_req_o, 1'b0);
    checkOutput("rst_we",    bus.mem_we_o, 1'b0);
    checkOutput("rst_addr",  bus.mem_addr_o, 32'h0);
    checkOutput("rst_wdata", bus.mem_wdata_o, '0);
    checkOutput("rst_rdata", bus.cpu_rdata_o, 32'h0);
    bus.cpu_rd_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checking = 1;

    $display("[TB] clean miss, store hit, load hit");
    applyStimulus(1, 0, 32'h40, 32'h0, 3, s, r);
    checkOutput("first_miss_stalls", 32'(s), 32'd4);
    checkOutput("first_miss_data", r, 32'h0040FFBF);
    applyStimulus(0, 1, 32'h44, 32'hDEADBEEF, 2, s, r);
    checkOutput("store_hit_stalls", 32'(s), 32'd0);
    applyStimulus(1, 0, 32'h44, 32'h0, 2, s, r);
    checkOutput("load_hit_stalls", 32'(s), 32'd0);
    checkOutput("load_hit_data", r, 32'hDEADBEEF);

    $display("[TB] dirty miss with write-back");
    applyStimulus(1, 0, 32'h244, 32'h0, 2, s, r);
    checkOutput("dirty_miss_stalls", 32'(s), 32'd5);
    checkOutput("wb_line_addr", last_wb_addr, 32'h40);
    checkOutput("wb_line_word1", last_wb_line[63:32], 32'hDEADBEEF);
    checkOutput("dirty_miss_data", r, 32'h0244FDBB);

    $display("[TB] read+write treated as store");
    applyStimulus(1, 1, 32'h248, 32'h12345678, 1, s, r);
    checkOutput("rdwr_stalls", 32'(s), 32'd0);
    applyStimulus(1, 0, 32'h248, 32'h0, 1, s, r);
    checkOutput("rdwr_readback", r, 32'h12345678);
    applyStimulus(1, 0, 32'h48, 32'h0, 1, s, r);
    checkOutput("rdwr_dirty_stalls", 32'(s), 32'd3);

    $display("[TB] reset during allocate");
    checking = 0;
    lat = 5;
    bus.cpu_rd_i   = 1'b1;
    bus.cpu_addr_i = 32'h440;
    repeat (3) @(negedge clk_i);
    checkOutput("alloc_before_reset", bus.mem_req_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midrst_req",   bus.mem_req_o, 1'b0);
    checkOutput("midrst_stall", bus.cpu_stall_o, 1'b0);
    checkOutput("midrst_addr",  bus.mem_addr_o, 32'h0);
    checkOutput("midrst_we",    bus.mem_we_o, 1'b0);
    checkOutput("midrst_rdata", bus.cpu_rdata_o, 32'h0);
    model_reset();
    bus.cpu_rd_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checking = 1;
    applyStimulus(1, 0, 32'h40, 32'h0, 2, s, r);
    checkOutput("post_rst_miss_stalls", 32'(s), 32'd3);
    applyStimulus(1, 0, 32'h44, 32'h0, 2, s, r);
    checkOutput("post_rst_wb_kept", r, 32'hDEADBEEF);
    applyStimulus(1, 0, 32'h48, 32'h0, 2, s, r);
`ifdef DCACHE_STATS_EN
    checkOutput("stats_hits",   hit_cnt_o, 32'd2);
    checkOutput("stats_misses", miss_cnt_o, 32'd1);
`endif

    $display("[TB] random accesses");
    for (int k = 0; k < 250 && !aborted; k++) begin
      logic [31:0] a;
      int          op;
      int          gap;
      a   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
            ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op  = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      applyStimulus(op != 1, op != 0, a, $urandom, $urandom_range(1, 4), s, r);
      repeat (gap) begin
        @(posedge clk_i); #1;
      end
    end
`ifdef DCACHE_STATS_EN
    checkOutput("stats_hits_total",   hit_cnt_o, 32'(model_hits));
    checkOutput("stats_misses_total", miss_cnt_o, 32'(model_misses));
`endif

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- MEM-stage data cache controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered memory access: read/write, ALU address, store data.
- Serves hits in zero stall cycles from a direct-mapped, write-back, write-allocate cache.
- On a miss, runs a req/ack handshake with off-chip memory and holds `cpu_stall_o`, which freezes the pipeline registers.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2); IDX_W = log2(NUM_LINES).
- LINE_W, 256, line width in bits (8 words of 32 bits); offset field = 5 bits.
- TAG_W, 32-5-IDX_W (23 at defaults), tag width; derived, not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_rd_i  in  1  load request (MemRead from EX/MEM).
- cpu_wr_i  in  1  store request (MemWrite from EX/MEM).
- cpu_addr_i  in  32  byte address (ALUResult from EX/MEM).
- cpu_wdata_i  in  32  store data (MemData from EX/MEM).
- cpu_rdata_o  out  32  load data, valid when cpu_rd_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  pipeline stall request.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1=line write-back, 0=line fill.
- mem_addr_o  out  32  line-aligned address, bits[4:0]=0.
- mem_wdata_o  out  LINE_W  victim line for write-back.
- mem_rdata_i  in  LINE_W  fill data, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - tag = addr[31:5+IDX_W]
  - idx = addr[5+IDX_W-1:5]
  - word = addr[4:2]
  - addr[1:0] ignored (word accesses only).
- Storage: per line valid, dirty, tag, LINE_W data, all internal registers.
- Reset (rst_i=0, any time including mid-miss):
  - state=IDLE; all valid and dirty bits 0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - cpu_rdata_o=0; cpu_stall_o=0.
  - Tag and data contents don't-care.
- req = cpu_rd_i | cpu_wr_i. If both are asserted, the access is treated as a store.
- hit = valid[idx] & (tag[idx]==tag).
- IDLE:
  - cpu_stall_o = req & ~hit, combinational, same cycle.
  - Read hit: cpu_rdata_o = selected word, combinationally; otherwise cpu_rdata_o=0.
  - Write hit: on the clock edge, the selected word is replaced and dirty[idx] is set to 1.
  - Miss with victim valid & dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK:
  - cpu_stall_o=1; mem_req_o=1; mem_we_o=1.
  - mem_addr_o = {victim tag, idx, 5'b0}; mem_wdata_o = victim line.
  - All memory outputs held stable until mem_ack_i.
  - On ack: go to ALLOCATE.
- ALLOCATE:
  - cpu_stall_o=1; mem_req_o=1; mem_we_o=0; mem_addr_o = {tag, idx, 5'b0}.
  - On ack, in the same edge: data[idx]=mem_rdata_i, tag[idx]=tag, valid=1, dirty=0; go to IDLE.
- Completion after the fill:
  - Next IDLE cycle hits; stall drops.
  - A pending store completes there as a write hit and sets dirty.
- Stall length (ack arrives N cycles after req rises, N>=1):
  - Clean miss: N+1 stall cycles.
  - Dirty miss: 2N+1 stall cycles.
- CPU inputs must stay stable while cpu_stall_o=1; the upstream stage holds them.
- A mem_ack_i in IDLE is ignored.
- mem_req_o drops in the cycle after the ack edge.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Counters reset to 0 and wrap at 2^32.
  - hit_cnt_o increments once per access completing on first lookup.
  - miss_cnt_o increments once per IDLE-to-miss transition; the re-lookup after a fill is not counted as a hit.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x0000_0040 with mem ack after 3 cycles → WRITEBACK skipped; mem_req_o/mem_we_o=1/0 at addr 0x40; 4 stall cycles; cpu_rdata_o = word 0 of the fill line.
- Store 0xDEAD_BEEF to 0x44, then load 0x44 → both complete with no stall; load returns 0xDEADBEEF; dirty[2]=1.
- Load 0x0000_0244 (same idx 2, new tag) → WRITEBACK at 0x40 with the line containing 0xDEADBEEF in word 1, then ALLOCATE at 0x240; stall = 2N+1.
- Assert rst_i low during ALLOCATE → mem_req_o=0 immediately; following load of 0x40 misses (valid cleared).
- Set cpu_rd_i=1 and cpu_wr_i=1 to 0x48 on a hit → treated as store; dirty set; no stall.
- With DCACHE_STATS_EN, sequence of hit, miss, hit → hit_cnt_o=2, miss_cnt_o=1.
